// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Initiator side of the 32-bit ALU interface. Accepts a decoded
//            operation over a valid/ready request channel, translates
//            ALUOp/funct3/funct7[5] into the 4-bit ALU control code, holds the
//            ALU inputs stable for a settle window, captures result and zero
//            flag, and returns result/zero/branch decision/error over a
//            valid/ready response channel.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready, req_aluop, req_funct3, req_funct7b5,
//            req_a, req_b                      -- request channel
//            alu_a, alu_b, alu_ctrl            -- to ALU
//            alu_result, alu_zero              -- from ALU
//            rsp_valid/rsp_ready, rsp_result, rsp_zero, rsp_taken, rsp_err
//                                              -- response channel
//            op_count                          -- completed responses (sat.)
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int          SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [SC_W-1:0] r_settle;
  logic            r_err;
  logic [1:0]      r_aluop;
  logic [2:0]      r_funct3;

  logic [3:0]      w_ctrl;
  logic            w_err;
  logic            w_taken;

  // Control decode of the incoming request; only consumed on accept.
  always_comb begin
    w_ctrl = CTRL_BAD;
    w_err  = 1'b1;
    case (req_aluop)
      2'b00: begin
        w_ctrl = CTRL_ADD;
        w_err  = 1'b0;
      end
      2'b01: begin
        // Branches always subtract; only BEQ/BNE are legal conditions.
        w_ctrl = CTRL_SUB;
        w_err  = !((req_funct3 == 3'b000) || (req_funct3 == 3'b001));
      end
      2'b10: begin
        w_err = 1'b0;
        case (req_funct3)
          3'b000:  w_ctrl = req_funct7b5 ? CTRL_SUB : CTRL_ADD;
          3'b111:  w_ctrl = CTRL_AND;
          3'b110:  w_ctrl = CTRL_OR;
          default: begin
            w_ctrl = CTRL_BAD;
            w_err  = 1'b1;
          end
        endcase
      end
      default: begin
        w_ctrl = CTRL_BAD;
        w_err  = 1'b1;
      end
    endcase
  end

  // Branch decision uses the live zero flag at the capture edge.
  assign w_taken = (r_aluop == 2'b01) &&
                   (((r_funct3 == 3'b000) &&  alu_zero) ||
                    ((r_funct3 == 3'b001) && !alu_zero));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_settle   <= '0;
      r_err      <= 1'b0;
      r_aluop    <= 2'b00;
      r_funct3   <= 3'b000;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= CTRL_BAD;
      op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_ctrl  <= w_ctrl;
            r_err     <= w_err;
            r_aluop   <= req_aluop;
            r_funct3  <= req_funct3;
            r_settle  <= SC_LOAD;
            req_ready <= 1'b0;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_settle == '0) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_taken  <= w_taken;
            rsp_err    <= r_err;
            rsp_valid  <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        ST_RESP: begin
          // req_ready returns only on the following cycle, so a request
          // can never be accepted on the response handshake edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. A transaction-level
//            model predicts every output each cycle for the main instance;
//            a second instance (settle 3, 2-bit counter) covers latency and
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int W      = 32;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  // main instance
  logic          req_valid, req_ready;
  logic [1:0]    req_aluop;
  logic [2:0]    req_funct3;
  logic          req_funct7b5;
  logic [W-1:0]  req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]    alu_ctrl;
  logic          alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_taken, rsp_err;
  logic [15:0]   op_count;
  // second instance
  logic          b_req_valid, b_req_ready;
  logic [W-1:0]  b_req_a, b_alu_a, b_alu_b, b_alu_result, b_rsp_result;
  logic [3:0]    b_alu_ctrl;
  logic          b_alu_zero, b_rsp_valid, b_rsp_ready, b_rsp_zero, b_rsp_taken, b_rsp_err;
  logic [1:0]    b_op_count;

  int checks = 0;
  int errors = 0;

  // ---------------- reference functions (from the operation tables) -------
  function automatic logic [3:0] dec_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic b5);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd2 && f3 == 3'd0) return b5 ? 4'b0110 : 4'b0010;
    if (op == 2'd2 && f3 == 3'd7) return 4'b0000;
    if (op == 2'd2 && f3 == 3'd6) return 4'b0001;
    return 4'b1111;
  endfunction

  function automatic logic dec_err(input logic [1:0] op, input logic [2:0] f3);
    if (op == 2'd0) return 1'b0;
    if (op == 2'd1) return !(f3 == 3'd0 || f3 == 3'd1);
    if (op == 2'd2) return !(f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6);
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return '0;
    endcase
  endfunction

  function automatic logic zero_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    if (c == 4'b1111) return 1'b0;
    return alu_fn(a, b, c) == '0;
  endfunction

  function automatic logic taken_fn(input logic [1:0] op, input logic [2:0] f3, input logic z);
    return (op == 2'd1) && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
  endfunction

  // ---------------- ALU models driving the DUT inputs ---------------------
  always_comb begin
    alu_result   = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero     = zero_fn(alu_a, alu_b, alu_ctrl);
    b_alu_result = alu_fn(b_alu_a, b_alu_b, b_alu_ctrl);
    b_alu_zero   = zero_fn(b_alu_a, b_alu_b, b_alu_ctrl);
  end

  alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_taken(rsp_taken), .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_aluop(2'b00),
    .req_funct3(3'b000), .req_funct7b5(1'b0), .req_a(b_req_a), .req_b(32'd1),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_ctrl(b_alu_ctrl),
    .alu_result(b_alu_result), .alu_zero(b_alu_zero),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
    .rsp_zero(b_rsp_zero), .rsp_taken(b_rsp_taken), .rsp_err(b_rsp_err), .op_count(b_op_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the main instance ----------
  logic          m_busy, m_valid, m_dec_err, m_zero, m_taken, m_err;
  int            m_age;
  logic [W-1:0]  m_a, m_b, m_res;
  logic [3:0]    m_ctrl;
  logic [1:0]    m_op;
  logic [2:0]    m_f3;
  logic [15:0]   m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_age <= 0;
      m_a <= '0; m_b <= '0; m_ctrl <= 4'hF; m_res <= '0;
      m_zero <= 1'b0; m_taken <= 1'b0; m_err <= 1'b0; m_dec_err <= 1'b0;
      m_op <= 2'd0; m_f3 <= 3'd0; m_cnt <= '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy    <= 1'b1;
        m_age     <= 0;
        m_a       <= req_a;
        m_b       <= req_b;
        m_ctrl    <= dec_ctrl(req_aluop, req_funct3, req_funct7b5);
        m_dec_err <= dec_err(req_aluop, req_funct3);
        m_op      <= req_aluop;
        m_f3      <= req_funct3;
      end
    end else if (m_age < SETTLE) begin
      m_age <= m_age + 1;
      if (m_age + 1 == SETTLE) begin
        m_res   <= alu_fn(m_a, m_b, m_ctrl);
        m_zero  <= zero_fn(m_a, m_b, m_ctrl);
        m_taken <= taken_fn(m_op, m_f3, zero_fn(m_a, m_b, m_ctrl));
        m_err   <= m_dec_err;
        m_valid <= 1'b1;
      end
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
    end
  end

  // ---------------- per-cycle compare -------------------------------------
  initial begin
    @(posedge reset);
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, !m_busy);
      check("rsp_valid", rsp_valid, m_valid);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_ctrl", alu_ctrl, m_ctrl);
      check("op_count", op_count, m_cnt);
      if (m_valid) begin
        check("rsp_result", rsp_result, m_res);
        check("rsp_zero", rsp_zero, m_zero);
        check("rsp_taken", rsp_taken, m_taken);
        check("rsp_err", rsp_err, m_err);
      end
    end
  end

  // ---------------- directed stimulus -------------------------------------
  logic [W-1:0] r_res;
  logic         r_z, r_t, r_e;
  logic [3:0]   r_c;

  // One request/response transaction; during `stall` cycles of response
  // backpressure a competing request is presented and must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_aluop = op; req_funct3 = f3; req_funct7b5 = b5;
    req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    r_c = alu_ctrl;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    r_res = rsp_result; r_z = rsp_zero; r_t = rsp_taken; r_e = rsp_err;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_aluop = 2'b10; req_funct3 = 3'b111;
      req_a = 32'hDEAD_BEEF; req_b = 32'h1;
      @(negedge clk);
      check("bp_result_stable", rsp_result, r_res);
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    req_valid = 0; req_aluop = 0; req_funct3 = 0; req_funct7b5 = 0;
    req_a = 0; req_b = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_a = 0; b_rsp_ready = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_alu_ctrl", alu_ctrl, 4'hF);
    check("rst_op_count", op_count, 0);
    reset = 1'b0;

    run_op(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 0);
    check("add_ctrl", r_c, 4'b0010);
    check("add_result", r_res, 32'd12);
    check("add_flags", {r_z, r_t, r_e}, 3'b000);
    check("add_model", m_res, 32'd12);
    check("add_count", op_count, 16'd1);

    run_op(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, 0);
    check("beq_ctrl", r_c, 4'b0110);
    check("beq_result", r_res, 32'd0);
    check("beq_flags", {r_z, r_t, r_e}, 3'b110);

    run_op(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234, 0);
    check("bne_flags", {r_z, r_t, r_e}, 3'b100);

    run_op(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    check("and_result", r_res, 32'hF000_F000);
    check("and_ctrl", r_c, 4'b0000);
    run_op(2'b10, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    check("or_result", r_res, 32'hFFF0_FFF0);
    check("or_model", m_res, 32'hFFF0_FFF0);

    run_op(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 0);
    check("sub_result", r_res, 32'd7);
    run_op(2'b00, 3'b010, 1'b0, 32'd100, 32'd20, 0);
    check("ldst_result", r_res, 32'd120);

    run_op(2'b10, 3'b010, 1'b0, 32'd9, 32'd9, 0);
    check("ill_ctrl", r_c, 4'hF);
    check("ill_result", r_res, 32'd0);
    check("ill_flags", {r_z, r_t, r_e}, 3'b001);
    check("ill_count", op_count, 16'd8);

    run_op(2'b01, 3'b100, 1'b0, 32'd5, 32'd5, 0);
    check("badbr_flags", {r_z, r_t, r_e}, 3'b101);
    run_op(2'b11, 3'b000, 1'b0, 32'd1, 32'd2, 0);
    check("op11_ctrl", r_c, 4'hF);
    check("op11_err", r_e, 1'b1);

    run_op(2'b10, 3'b000, 1'b0, 32'd40, 32'd2, 5);
    check("bp_result", r_res, 32'd42);
    check("bp_count", op_count, 16'd11);
    check("bp_idle_after", req_ready, 1'b1);

    // reset during ISSUE
    @(negedge clk);
    req_valid = 1'b1; req_aluop = 2'b10; req_funct3 = 3'b000; req_a = 32'd3; req_b = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_iss_ready", req_ready, 1'b1);
    check("rst_iss_valid", rsp_valid, 1'b0);
    check("rst_iss_alu", {alu_a, alu_b}, 64'd0);
    check("rst_iss_ctrl", alu_ctrl, 4'hF);
    check("rst_iss_count", op_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_iss_norsp", rsp_valid, 1'b0);

    // reset during RESP
    run_op(2'b10, 3'b000, 1'b0, 32'd1, 32'd1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_aluop = 2'b10; req_funct3 = 3'b110; req_a = 32'h10; req_b = 32'h01;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("resp_reached", rsp_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", {rsp_result, rsp_zero, rsp_taken, rsp_err}, 0);
    check("rst_rsp_count", op_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_norsp", rsp_valid, 1'b0);

    // settle 3 latency and 2-bit counter saturation
    for (int i = 0; i < 4; i++) begin
      int n;
      @(negedge clk);
      b_req_valid = 1'b1; b_req_a = 32'(i * 10);
      @(negedge clk);
      b_req_valid = 1'b0;
      n = 0;
      while (!b_rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("s3_latency", n, 3);
      check("s3_result", b_rsp_result, 32'(i * 10 + 1));
      check("s3_flags", {b_rsp_zero, b_rsp_taken, b_rsp_err, b_req_ready}, 4'b0000);
      b_rsp_ready = 1'b1;
      @(negedge clk);
      b_rsp_ready = 1'b0;
      check("s3_count", b_op_count, (i >= 2) ? 2'd3 : 2'(i + 1));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 32-bit ALU interface.
- Accepts decoded operations from the datapath over a valid/ready request channel and translates ALUOp/funct3/funct7 into the ALU's 4-bit control code.
- Drives the ALU operand and control inputs, then captures the ALU result and zero flag after a settle window.
- Returns result, zero, branch decision and error over a valid/ready response channel; used by the multi-cycle and FPGA-timing-relaxed datapath variants.

Parameters:
- WIDTH, 32, operand/result width
- SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before capture (≥1)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved
- req_funct3  in  3  instruction funct3
- req_funct7b5  in  1  instruction bit 30
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_ctrl  out  4  to ALU control
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured zero
- rsp_taken  out  1  branch decision
- rsp_err  out  1  illegal operation flag
- op_count  out  CNT_W  completed responses, saturating

Behaviour:
- Control decode (registered at accept):
  - aluop 00 → ADD 0010.
  - aluop 01 → SUB 0110.
  - aluop 10:
    - funct3 000 & b5=0 → ADD 0010
    - funct3 000 & b5=1 → SUB 0110
    - funct3 111 → AND 0000
    - funct3 110 → OR 0001
  - Anything else, including aluop 11 → ctrl 1111, err=1.
- Branch decision (aluop 01 only):
  - funct3 000 (BEQ): taken = captured zero.
  - funct3 001 (BNE): taken = !zero.
  - Other funct3 → taken=0, err=1.
  - Non-branch ops: taken=0.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: req_ready=1. On req_valid, latch operands, ctrl, err, aluop, funct3; load settle counter with SETTLE_CYCLES-1; go to ISSUE.
  - ISSUE: alu_a/alu_b/alu_ctrl driven from the latched registers and held stable. Counter decrements each cycle. When counter=0, capture alu_result/alu_zero into rsp_result/rsp_zero, compute rsp_taken, go to RESP.
  - RESP: rsp_valid=1; all rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready, increment op_count (saturating at all-ones) and go to IDLE.
- Error ops still traverse ISSUE with ctrl 1111; the ALU returns result 0, zero 0, and these are reported as captured.
- req_ready is 0 in ISSUE and RESP; no new request is accepted in the same cycle as a response handshake.
- Latency with SETTLE_CYCLES=1:
  - Accept edge N.
  - Capture edge N+1.
  - rsp_valid high after N+1.
  - Next accept no earlier than edge N+3 (rsp_ready high at N+2).
  - General case: rsp_valid asserts SETTLE_CYCLES cycles after accept.
- Outside ISSUE, alu_a/alu_b keep their last latched value and alu_ctrl keeps its last code.
- Reset (asynchronous, any state, including mid-ISSUE or mid-RESP) sets:
  - state IDLE, req_ready=1, rsp_valid=0
  - rsp_result=0, rsp_zero=0, rsp_taken=0, rsp_err=0
  - alu_a=0, alu_b=0, alu_ctrl=1111
  - op_count=0
  - Any in-flight operation is dropped with no response.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored when rsp_valid=0.

Test Plan:
- Reset, then R-type ADD a=5, b=7 (aluop 10, f3 000, b5 0) → alu_ctrl=0010 during ISSUE; rsp_result=12, zero=0, taken=0, err=0; op_count=1.
- BEQ a=b=0x1234 (aluop 01, f3 000) → ctrl 0110; rsp_result=0, zero=1, taken=1. Repeat as BNE (f3 001) → taken=0.
- R-type AND 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000. OR of the same operands → 0xFFF0_FFF0.
- Illegal op (aluop 10, f3 010) → ctrl 1111; rsp_result=0, err=1; op_count still increments.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0, a second req_valid is ignored. Release → one handshake, then IDLE. Also with SETTLE_CYCLES=3: rsp_valid first high 3 cycles after accept.
- Assert reset mid-ISSUE and mid-RESP → all outputs at reset values immediately, no response emitted, op_count=0. Force op_count to all-ones (CNT_W=2, 4 ops) → it saturates at 3.
